decode_fifo: RTL

Parametrised instruction decode buffer for the MIPS datapath. It sits between fetch and decode and holds up to DEPTH fetched words, each with its PC, using valid/ready handshakes. It presents the oldest entry split into all R/I/J fields. It adds stall, flush and back-pressure capability beyond a single fixed R-type field splitter.

---
 rtl/decode_fifo_if.sv | 39 +++
 rtl/decode_fifo.sv | 88 ++++++++
 2 files changed

// File: rtl/decode_fifo_if.sv
// Fetch-to-decode bundle: fetch handshake in, split head fields and occupancy out.
// slave modport faces the buffer, master modport faces the surrounding datapath.
interface decode_fifo_if #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [PC_W-1:0]  in_pc;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [PC_W-1:0]  out_pc;
   logic [5:0]       opcode;
   logic [4:0]       rsOut;
   logic [4:0]       rtOut;
   logic [4:0]       rdOut;
   logic [4:0]       shamt;
   logic [5:0]       funOut;
   logic [31:0]      imm;
   logic [25:0]      target;
   logic             is_rtype;
   logic [CNT_W-1:0] count;

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, opcode, rsOut, rtOut, rdOut,
             shamt, funOut, imm, target, is_rtype, count
   );

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, opcode, rsOut, rtOut, rdOut,
             shamt, funOut, imm, target, is_rtype, count
   );
endinterface

// File: rtl/decode_fifo.sv
// Decode buffer: DEPTH-entry circular FIFO of {instr, pc}, head split into R/I/J fields, 1-cycle push-to-visible latency.
// in_ready = !full (no path from out_ready); flush beats push/pop. IMM_SEXT_EN selects sign-extended imm.
module decode_fifo #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic          clk,
   input  logic          rst,
   decode_fifo_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [31:0]      mem_q [DEPTH];
   logic [PC_W-1:0]  pc_q  [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic full, empty, push, pop;
   logic [31:0]     head;
   logic [PC_W-1:0] head_pc;

   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);
   assign push  = bus.in_valid && !full;
   assign pop   = bus.out_ready && !empty;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (bus.flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + 1'b1;
         if (pop)  rptr_d = rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      if (push && !bus.flush) begin
         mem_q[wptr_q] <= bus.in_instr;
         pc_q[wptr_q]  <= bus.in_pc;
      end
   end

   assign head    = empty ? 32'd0 : mem_q[rptr_q];
   assign head_pc = empty ? '0 : pc_q[rptr_q];

   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.count     = cnt_q;
   assign bus.out_pc    = head_pc;
   assign bus.opcode    = head[31:26];
   assign bus.rsOut     = head[25:21];
   assign bus.rtOut     = head[20:16];
   assign bus.rdOut     = head[15:11];
   assign bus.shamt     = head[10:6];
   assign bus.funOut    = head[5:0];
   assign bus.target    = head[25:0];
   assign bus.is_rtype  = !empty && (head[31:26] == 6'b000000);
`ifdef IMM_SEXT_EN
   assign bus.imm       = {{16{head[15]}}, head[15:0]};
`else
   assign bus.imm       = {16'b0, head[15:0]};
`endif
endmodule
